// File: rtl/game_pkg.sv
// Shared types and default constants for the game sequencer.
package game_pkg;

   typedef enum logic [1:0] {
      ST_MENU,
      ST_PLAYING,
      ST_CONTINUE,
      ST_FINAL
   } game_state_e;

   localparam int unsigned LIVES_INIT_DEF      = 3;
   localparam int unsigned SCORE_BITS_DEF      = 8;
   localparam int unsigned WIN_SCORE_DEF       = 20;
   localparam int unsigned CONTINUE_FRAMES_DEF = 600;
   localparam int unsigned FINAL_FRAMES_DEF    = 300;
   localparam int unsigned CNT_BITS_DEF        = 10;

   // One-hot screen flags, packed {final, continue, playing, menu}.
   function automatic logic [3:0] state_flags(input game_state_e st);
      logic [3:0] f;
      f = 4'b0000;
      unique case (st)
         ST_MENU:     f = 4'b0001;
         ST_PLAYING:  f = 4'b0010;
         ST_CONTINUE: f = 4'b0100;
         ST_FINAL:    f = 4'b1000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/game_state_ctrl_countdown.sv
// Loadable frame down-counter shared by the CONTINUE and FINAL screens.
module frame_countdown #(
   parameter int unsigned CNT_BITS = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [CNT_BITS-1:0] load_val_i,
   input  logic                tick_i,
   output logic [CNT_BITS-1:0] count_o,
   output logic                zero_o,
   output logic                last_o
);

   logic [CNT_BITS-1:0] cnt_q;

   // Load has priority over the per-frame decrement; the count parks at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_BITS'(1);
      end
   end

   assign count_o = cnt_q;
   assign zero_o  = (cnt_q == '0);
   // One frame left: the next tick brings the count to zero.
   assign last_o  = (cnt_q == CNT_BITS'(1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: MENU/PLAYING/CONTINUE/FINAL with lives/score tracking.
// Screen changes are requested at any time but only committed on a frame tick.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INIT      = LIVES_INIT_DEF,
   parameter int unsigned SCORE_BITS      = SCORE_BITS_DEF,
   parameter int unsigned WIN_SCORE       = WIN_SCORE_DEF,
   parameter int unsigned CONTINUE_FRAMES = CONTINUE_FRAMES_DEF,
   parameter int unsigned FINAL_FRAMES    = FINAL_FRAMES_DEF,
   parameter int unsigned CNT_BITS        = CNT_BITS_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  frame_tick_i,
   input  logic                  start_btn_i,
   input  logic                  player_hit_i,
   input  logic                  enemy_kill_i,
   output logic                  is_menu_o,
   output logic                  is_playing_o,
   output logic                  is_continue_o,
   output logic                  is_final_o,
   output logic                  game_reset_o,
   output logic [1:0]            lives_o,
   output logic [SCORE_BITS-1:0] score_o,
   output logic [CNT_BITS-1:0]   countdown_o,
   output logic                  win_o
);

   localparam logic [SCORE_BITS-1:0] SCORE_MAX  = '1;
   localparam logic [SCORE_BITS-1:0] SCORE_WIN  = SCORE_BITS'(WIN_SCORE);
   localparam logic [1:0]            LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [CNT_BITS-1:0]   CONT_LOAD  = CNT_BITS'(CONTINUE_FRAMES);
   localparam logic [CNT_BITS-1:0]   FINAL_LOAD = CNT_BITS'(FINAL_FRAMES);

   game_state_e           state_q, state_d;
   game_state_e           tgt_q, tgt_d;
   game_state_e           new_tgt, tgt;
   logic                  pend_q, pend_d;
   logic                  start_q;
   logic [1:0]            lives_q, lives_d;
   logic [SCORE_BITS-1:0] score_q, score_d;
   logic                  win_q, win_d;
   logic                  game_reset_q, game_reset_d;
   logic [3:0]            flags_q;
   logic                  start_edge, new_req, req, commit, kill_win, lives_out;
   logic                  cnt_expire, cnt_zero, cnt_last;
   logic [CNT_BITS-1:0]   cnt_val, cnt_count;

   assign start_edge = start_btn_i & ~start_q;
   // Counter hits zero on this tick (or is already there).
   assign cnt_expire = frame_tick_i & (cnt_zero | cnt_last);

   frame_countdown #(
      .CNT_BITS (CNT_BITS)
   ) u_countdown (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (commit),
      .load_val_i (cnt_val),
      .tick_i     (frame_tick_i),
      .count_o    (cnt_count),
      .zero_o     (cnt_zero),
      .last_o     (cnt_last)
   );

   // Next-state: gameplay bookkeeping, transition requests and frame-aligned commit.
   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      pend_d       = pend_q;
      lives_d      = lives_q;
      score_d      = score_q;
      win_d        = win_q;
      game_reset_d = 1'b0;
      new_req      = 1'b0;
      new_tgt      = tgt_q;
      kill_win     = 1'b0;
      lives_out    = 1'b0;
      cnt_val      = '0;

      unique case (state_q)
         ST_MENU: begin
            if (start_edge) begin
               new_req = 1'b1;
               new_tgt = ST_PLAYING;
            end
         end
         ST_PLAYING: begin
            // A pending request freezes the score and lives until the commit.
            if (!pend_q) begin
               if (enemy_kill_i) begin
                  if (score_q != SCORE_MAX) score_d = score_q + SCORE_BITS'(1);
                  if (score_d == SCORE_WIN) begin
                     win_d    = 1'b1;
                     kill_win = 1'b1;
                  end
               end
               if (player_hit_i && (lives_q != 2'd0)) begin
                  lives_d   = lives_q - 2'd1;
                  lives_out = (lives_d == 2'd0);
               end
               // A win outranks running out of lives in the same cycle.
               if (kill_win) begin
                  new_req = 1'b1;
                  new_tgt = ST_FINAL;
               end else if (lives_out) begin
                  new_req = 1'b1;
                  new_tgt = ST_CONTINUE;
               end
            end
         end
         ST_CONTINUE: begin
            if (start_edge) begin
               new_req = 1'b1;
               new_tgt = ST_PLAYING;
            end else if (!pend_q && cnt_expire) begin
               new_req = 1'b1;
               new_tgt = ST_FINAL;
            end
         end
         ST_FINAL: begin
            if (start_edge || cnt_expire) begin
               new_req = 1'b1;
               new_tgt = ST_MENU;
            end
         end
      endcase

      req    = pend_q | new_req;
      tgt    = new_req ? new_tgt : tgt_q;
      commit = frame_tick_i & req;

      if (commit) begin
         state_d = tgt;
         pend_d  = 1'b0;
         unique case (tgt)
            ST_MENU: begin
               lives_d = LIVES_LOAD;
               score_d = '0;
               win_d   = 1'b0;
            end
            ST_PLAYING: begin
               lives_d      = LIVES_LOAD;
               game_reset_d = 1'b1;
               // Continuing keeps the score; a fresh game from the menu clears it.
               if (state_q == ST_MENU) begin
                  score_d = '0;
                  win_d   = 1'b0;
               end
            end
            ST_CONTINUE: cnt_val = CONT_LOAD;
            ST_FINAL:    cnt_val = FINAL_LOAD;
         endcase
      end else begin
         pend_d = req;
         tgt_d  = tgt;
      end
   end

   // State and bookkeeping registers; flags are registered from the next state
   // so they change on the cycle right after the commit edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_MENU;
         tgt_q        <= ST_MENU;
         pend_q       <= 1'b0;
         start_q      <= 1'b0;
         lives_q      <= LIVES_LOAD;
         score_q      <= '0;
         win_q        <= 1'b0;
         game_reset_q <= 1'b0;
         flags_q      <= state_flags(ST_MENU);
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         pend_q       <= pend_d;
         start_q      <= start_btn_i;
         lives_q      <= lives_d;
         score_q      <= score_d;
         win_q        <= win_d;
         game_reset_q <= game_reset_d;
         flags_q      <= state_flags(state_d);
      end
   end

   assign is_menu_o     = flags_q[0];
   assign is_playing_o  = flags_q[1];
   assign is_continue_o = flags_q[2];
   assign is_final_o    = flags_q[3];
   assign game_reset_o  = game_reset_q;
   assign lives_o       = lives_q;
   assign score_o       = score_q;
   assign countdown_o   = cnt_count;
   assign win_o         = win_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a one-hot flag monitor.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       frame_tick_i = 1'b0;
   logic       start_btn_i = 1'b0;
   logic       player_hit_i = 1'b0;
   logic       enemy_kill_i = 1'b0;
   logic       is_menu_o, is_playing_o, is_continue_o, is_final_o, game_reset_o, win_o;
   logic [1:0] lives_o;
   logic [7:0] score_o;
   logic [9:0] countdown_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   game_state_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .frame_tick_i  (frame_tick_i),
      .start_btn_i   (start_btn_i),
      .player_hit_i  (player_hit_i),
      .enemy_kill_i  (enemy_kill_i),
      .is_menu_o     (is_menu_o),
      .is_playing_o  (is_playing_o),
      .is_continue_o (is_continue_o),
      .is_final_o    (is_final_o),
      .game_reset_o  (game_reset_o),
      .lives_o       (lives_o),
      .score_o       (score_o),
      .countdown_o   (countdown_o),
      .win_o         (win_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Frame tick: returns 1 time unit after the tick edge, when a commit is visible.
   task automatic do_tick();
      frame_tick_i = 1'b1;
      cyc(1);
      frame_tick_i = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         do_tick();
         cyc(1);
      end
   endtask

   task automatic press();
      start_btn_i = 1'b1;
      cyc(1);
      start_btn_i = 1'b0;
      cyc(1);
   endtask

   task automatic kill();
      enemy_kill_i = 1'b1;
      cyc(1);
      enemy_kill_i = 1'b0;
      cyc(1);
   endtask

   task automatic hit();
      player_hit_i = 1'b1;
      cyc(1);
      player_hit_i = 1'b0;
      cyc(1);
   endtask

   task automatic new_game();
      press();
      do_tick();
      check_eq("ng_playing", is_playing_o, 1);
      cyc(1);
   endtask

   always @(negedge clk) begin
      if (mon_en)
         check_eq("onehot", $countones({is_menu_o, is_playing_o, is_continue_o, is_final_o}), 1);
   end

   initial begin
      // Reset values
      cyc(2);
      rst_i = 1'b0;
      mon_en = 1'b1;
      check_eq("rst_menu", is_menu_o, 1);
      check_eq("rst_playing", is_playing_o, 0);
      check_eq("rst_greset", game_reset_o, 0);
      check_eq("rst_lives", lives_o, 3);
      check_eq("rst_score", score_o, 0);
      check_eq("rst_cd", countdown_o, 0);
      check_eq("rst_win", win_o, 0);

      // Gameplay pulse in MENU is ignored
      kill();
      check_eq("menu_kill_ign", score_o, 0);

      // 1: start mid-frame, held button, commit on next tick
      start_btn_i = 1'b1;
      cyc(4);
      check_eq("t1_menu_hold", is_menu_o, 1);
      do_tick();
      check_eq("t1_playing", is_playing_o, 1);
      check_eq("t1_greset", game_reset_o, 1);
      check_eq("t1_lives", lives_o, 3);
      check_eq("t1_score", score_o, 0);
      cyc(1);
      check_eq("t1_greset_1cyc", game_reset_o, 0);
      start_btn_i = 1'b0;
      cyc(1);

      // 2: win by kills, FINAL countdown, auto-return to MENU
      repeat (19) kill();
      check_eq("t2_score19", score_o, 19);
      check_eq("t2_win0", win_o, 0);
      kill();
      check_eq("t2_score20", score_o, 20);
      check_eq("t2_win1", win_o, 1);
      check_eq("t2_still_play", is_playing_o, 1);
      kill();
      check_eq("t2_pend_ign", score_o, 20);
      do_tick();
      check_eq("t2_final", is_final_o, 1);
      check_eq("t2_cd300", countdown_o, 300);
      cyc(1);
      ticks(299);
      check_eq("t2_cd1", countdown_o, 1);
      check_eq("t2_final_hold", is_final_o, 1);
      do_tick();
      check_eq("t2_menu", is_menu_o, 1);
      check_eq("t2_score0", score_o, 0);
      check_eq("t2_win_clr", win_o, 0);
      check_eq("t2_cd0", countdown_o, 0);
      cyc(1);

      // 3: lose lives, CONTINUE, restart at 450
      new_game();
      kill();
      kill();
      hit();
      hit();
      check_eq("t3_lives1", lives_o, 1);
      hit();
      check_eq("t3_lives0", lives_o, 0);
      check_eq("t3_still_play", is_playing_o, 1);
      do_tick();
      check_eq("t3_continue", is_continue_o, 1);
      check_eq("t3_cd600", countdown_o, 600);
      cyc(1);
      ticks(150);
      check_eq("t3_cd450", countdown_o, 450);
      press();
      check_eq("t3_cont_hold", is_continue_o, 1);
      do_tick();
      check_eq("t3_playing", is_playing_o, 1);
      check_eq("t3_lives3", lives_o, 3);
      check_eq("t3_score_kept", score_o, 2);
      check_eq("t3_greset", game_reset_o, 1);
      check_eq("t3_cd0", countdown_o, 0);
      cyc(1);
      check_eq("t3_greset_1cyc", game_reset_o, 0);

      // 4: CONTINUE times out into FINAL without a win, then start returns to MENU
      repeat (3) hit();
      do_tick();
      check_eq("t4_continue", is_continue_o, 1);
      cyc(1);
      ticks(599);
      check_eq("t4_cd1", countdown_o, 1);
      check_eq("t4_cont_hold", is_continue_o, 1);
      do_tick();
      check_eq("t4_final", is_final_o, 1);
      check_eq("t4_win0", win_o, 0);
      check_eq("t4_cd300", countdown_o, 300);
      cyc(1);
      press();
      check_eq("t4_final_hold", is_final_o, 1);
      do_tick();
      check_eq("t4_menu", is_menu_o, 1);
      check_eq("t4_score0", score_o, 0);
      cyc(1);

      // 5: hit+kill in the same cycle as a tick at lives=1, score=19
      new_game();
      repeat (19) kill();
      hit();
      hit();
      check_eq("t5_lives1", lives_o, 1);
      player_hit_i = 1'b1;
      enemy_kill_i = 1'b1;
      do_tick();
      player_hit_i = 1'b0;
      enemy_kill_i = 1'b0;
      check_eq("t5_final", is_final_o, 1);
      check_eq("t5_win1", win_o, 1);
      check_eq("t5_lives0", lives_o, 0);
      check_eq("t5_score20", score_o, 20);
      check_eq("t5_cd300", countdown_o, 300);
      cyc(1);
      press();
      do_tick();
      check_eq("t5_menu", is_menu_o, 1);
      cyc(1);

      // 6: reset with a CONTINUE request pending discards it
      new_game();
      repeat (3) hit();
      check_eq("t6_lives0", lives_o, 0);
      rst_i = 1'b1;
      cyc(1);
      rst_i = 1'b0;
      check_eq("t6_menu", is_menu_o, 1);
      check_eq("t6_lives", lives_o, 3);
      check_eq("t6_score", score_o, 0);
      check_eq("t6_cd", countdown_o, 0);
      check_eq("t6_greset", game_reset_o, 0);
      do_tick();
      check_eq("t6_no_commit", is_menu_o, 1);
      check_eq("t6_no_cont", is_continue_o, 0);
      cyc(2);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
